relu_pool: RTL and testbench

Post-convolution stage: takes the flattened multi-channel feature map produced by `conv`, applies ReLU and 2×2 stride-2 max pooling, and presents a flattened pooled map plus `done` to the next layer. It sits directly downstream of `conv`, driven from `conv`'s `out_mem_flat` and `done`. It is sequential: it captures the input on `start`, walks one window element per cycle, and writes one pooled result every 4 cycles.

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/signed_max_relu.sv | 24 ++
 rtl/relu_pool.sv | 188 ++++++++++++++++++
 tb/tb_relu_pool.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: default word format, layer FSM states
// and the flattened feature-map index helpers also used by conv.
package cnn_pkg;

    localparam int unsigned DEF_N = 16;
    localparam int unsigned DEF_Q = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Row/column offset of one element inside a 2x2 pooling window
    typedef struct packed {
        logic dy;
        logic dx;
    } win_off_t;

    // Flat element index of (c,y,x) in a channel-major, row-major map of the given side
    function automatic int unsigned feat_idx(input int unsigned c,
                                             input int unsigned y,
                                             input int unsigned x,
                                             input int unsigned side);
        return c * side * side + y * side + x;
    endfunction

    // Window walk order: (0,0), (0,1), (1,0), (1,1)
    function automatic win_off_t win_offset(input logic [1:0] w);
        win_off_t off;
        off.dy = w[1];
        off.dx = w[0];
        return off;
    endfunction

endpackage

// File: rtl/signed_max_relu.sv
// Combinational signed max of two words, optionally clamped at zero (ReLU).
module signed_max_relu
    import cnn_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    input  logic                clamp_i,
    output logic signed [N-1:0] max_c_o
);

    logic signed [N-1:0] larger_c;

    // Pick the larger operand, then zero it if negative and clamping is requested
    always_comb begin
        larger_c = (a_i > b_i) ? a_i : b_i;
        max_c_o  = larger_c;
        if (clamp_i && larger_c[N-1]) begin
            max_c_o = '0;
        end
    end

endmodule

// File: rtl/relu_pool.sv
// ReLU + 2x2 stride-2 max pooling over a captured multi-channel feature map.
// One window element per cycle; a pooled word is written every fourth cycle.
module relu_pool
    import cnn_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned Q        = DEF_Q,
    parameter int unsigned IN_SIDE  = 6,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                start,
    input  logic [N*CHANNELS*IN_SIDE*IN_SIDE-1:0]               in_flat,
    output logic [N*CHANNELS*(IN_SIDE/2)*(IN_SIDE/2)-1:0]       out_flat,
    output logic                                                busy,
    output logic                                                done
);

    localparam int unsigned P_SIDE = IN_SIDE / 2;
    localparam int unsigned IN_W   = N * CHANNELS * IN_SIDE * IN_SIDE;
    localparam int unsigned OUT_W  = N * CHANNELS * P_SIDE * P_SIDE;
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned P_W    = (P_SIDE > 1) ? $clog2(P_SIDE) : 1;
    localparam logic [OUT_W-1:0] WORD_MASK = OUT_W'({N{1'b1}});

    // Fractional bits only travel with the data format; a value outside the word is meaningless
    if (Q >= N) begin : g_q_outside_word
    end

    state_e                 state_q, state_d;
    logic [IN_W-1:0]        cap_q, cap_d;
    logic [OUT_W-1:0]       out_q, out_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [P_W-1:0]         py_q, py_d;
    logic [P_W-1:0]         px_q, px_d;
    logic [1:0]             w_q, w_d;
    logic signed [N-1:0]    run_max_q, run_max_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    win_off_t               off_c;
    int unsigned            rd_idx_c;
    int unsigned            wr_idx_c;
    logic signed [N-1:0]    elem_c;
    logic signed [N-1:0]    max_c;
    logic [N-1:0]           wr_word_c;
    logic                   last_c;
    logic                   px_wrap_c;
    logic                   py_wrap_c;

    assign out_flat = out_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Address the current window element and output slot, and flag the final slot
    always_comb begin
        off_c     = win_offset(w_q);
        rd_idx_c  = feat_idx(32'(ch_q),
                             32'(py_q) * 32'd2 + 32'(off_c.dy),
                             32'(px_q) * 32'd2 + 32'(off_c.dx),
                             IN_SIDE);
        wr_idx_c  = feat_idx(32'(ch_q), 32'(py_q), 32'(px_q), P_SIDE);
        elem_c    = N'(cap_q >> (rd_idx_c * N));
        px_wrap_c = (px_q == P_W'(P_SIDE - 1));
        py_wrap_c = (py_q == P_W'(P_SIDE - 1));
        last_c    = (ch_q == CH_W'(CHANNELS - 1)) && py_wrap_c && px_wrap_c;
    end

    // Running max; on the last window element the result is also ReLU-clamped
    signed_max_relu #(
        .N (N)
    ) u_max (
        .a_i     (run_max_q),
        .b_i     (elem_c),
        .clamp_i (w_q == 2'd3),
        .max_c_o (max_c)
    );

    assign wr_word_c = max_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start is honoured only outside RUN; the last slot write ends the run
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((w_q == 2'd3) && last_c) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status next values per state
    always_comb begin
        cap_d     = cap_q;
        out_d     = out_q;
        ch_d      = ch_q;
        py_d      = py_q;
        px_d      = px_q;
        w_d       = w_q;
        run_max_d = run_max_q;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cap_d     = in_flat;
                    ch_d      = '0;
                    py_d      = '0;
                    px_d      = '0;
                    w_d       = '0;
                    run_max_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end
            end
            RUN: begin
                w_d       = w_q + 2'd1;
                run_max_d = (w_q == 2'd0) ? elem_c : max_c;
                if (w_q == 2'd3) begin
                    out_d = (out_q & ~(WORD_MASK << (wr_idx_c * N)))
                          | (OUT_W'(wr_word_c) << (wr_idx_c * N));
                    if (px_wrap_c) begin
                        px_d = '0;
                        if (py_wrap_c) begin
                            py_d = '0;
                            ch_d = last_c ? '0 : ch_q + CH_W'(1);
                        end else begin
                            py_d = py_q + P_W'(1);
                        end
                    end else begin
                        px_d = px_q + P_W'(1);
                    end
                    if (last_c) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q     <= '0;
            out_q     <= '0;
            ch_q      <= '0;
            py_q      <= '0;
            px_q      <= '0;
            w_q       <= '0;
            run_max_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cap_q     <= cap_d;
            out_q     <= out_d;
            ch_q      <= ch_d;
            py_q      <= py_d;
            px_q      <= px_d;
            w_q       <= w_d;
            run_max_q <= run_max_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_relu_pool.sv
// Scoreboard bench for relu_pool: default 6x6x4 instance plus an odd 7x7x1 instance.
module tb_relu_pool;

    localparam int unsigned IN6_W  = 2304;
    localparam int unsigned OUT6_W = 576;
    localparam int unsigned IN7_W  = 784;
    localparam int unsigned OUT7_W = 144;

    logic               clk;
    logic               reset;
    logic               start6, start7;
    logic               busy6, done6, busy7, done7;
    logic [IN6_W-1:0]   in6;
    logic [OUT6_W-1:0]  out6;
    logic [IN7_W-1:0]   in7;
    logic [OUT7_W-1:0]  out7;

    typedef struct {
        int                id;
        logic [OUT6_W-1:0] v;
        int                start_cyc;
        int                lat;
        int                cnt;
    } exp_t;

    exp_t q6[$];
    exp_t q7[$];
    exp_t e6, e7;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic d6p   = 1'b0;
    logic d7p   = 1'b0;

    int ch0_ramp[9] = '{8, 10, 12, 20, 22, 24, 32, 34, 36};
    int odd_ramp[9] = '{9, 11, 13, 23, 25, 27, 37, 39, 41};

    relu_pool #(.N(16), .Q(8), .IN_SIDE(6), .CHANNELS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start6),
        .in_flat  (in6),
        .out_flat (out6),
        .busy     (busy6),
        .done     (done6)
    );

    relu_pool #(.N(16), .Q(8), .IN_SIDE(7), .CHANNELS(1)) dut7 (
        .clk      (clk),
        .reset    (reset),
        .start    (start7),
        .in_flat  (in7),
        .out_flat (out7),
        .busy     (busy7),
        .done     (done7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2303:0] put(input logic [2303:0] v, input int idx, input int val);
        logic [15:0]   w;
        logic [2303:0] m;
        w = 16'(val);
        m = 2304'(16'hFFFF) << (idx * 16);
        return (v & ~m) | (2304'(w) << (idx * 16));
    endfunction

    function automatic int get(input logic [2303:0] v, input int idx);
        logic [15:0] w;
        w = 16'(v >> (idx * 16));
        return int'($signed(w));
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [2303:0] ramp6();
        logic [2303:0] v = '0;
        for (int i = 0; i < 144; i++) v = put(v, i, i + 1);
        return v;
    endfunction

    function automatic logic [2303:0] fill6(input int val);
        logic [2303:0] v = '0;
        for (int i = 0; i < 144; i++) v = put(v, i, val);
        return v;
    endfunction

    function automatic logic [OUT6_W-1:0] ramp6_exp();
        logic [2303:0] v = '0;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 9; k++) v = put(v, c * 9 + k, ch0_ramp[k] + 36 * c);
        return OUT6_W'(v);
    endfunction

    // Default-instance monitor: on each done rise, pop and compare every slot and latency
    always @(negedge clk) begin
        if (done6 && !d6p) begin
            if (q6.size() == 0) begin
                chk("done6_with_empty_queue", q6.size(), 1);
            end else begin
                e6 = q6.pop_front();
                for (int i = 0; i < e6.cnt; i++)
                    chk($sformatf("run%0d_el%0d", e6.id, i), get(2304'(out6), i), get(2304'(e6.v), i));
                chk($sformatf("run%0d_done_latency", e6.id), cyc - e6.start_cyc, e6.lat);
            end
        end
        d6p = done6;
    end

    // Odd-size monitor
    always @(negedge clk) begin
        if (done7 && !d7p) begin
            if (q7.size() == 0) begin
                chk("done7_with_empty_queue", q7.size(), 1);
            end else begin
                e7 = q7.pop_front();
                for (int i = 0; i < e7.cnt; i++)
                    chk($sformatf("run%0d_el%0d", e7.id, i), get(2304'(out7), i), get(2304'(e7.v), i));
                chk($sformatf("run%0d_done_latency", e7.id), cyc - e7.start_cyc, e7.lat);
            end
        end
        d7p = done7;
    end

    // Pulse start into one instance; optionally register the expected result for its monitor
    task automatic go(input bit is7, input int id, input logic [OUT6_W-1:0] ev, input bit push);
        exp_t e;
        @(negedge clk);
        if (is7) start7 = 1'b1; else start6 = 1'b1;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        start7 = 1'b0;
        e.id        = id;
        e.v         = ev;
        e.start_cyc = cyc;
        e.lat       = is7 ? 36 : 144;
        e.cnt       = is7 ? 9 : 36;
        if (push) begin
            if (is7) q7.push_back(e); else q6.push_back(e);
        end
        chk($sformatf("run%0d_busy_after_accept", id), int'(is7 ? busy7 : busy6), 1);
        chk($sformatf("run%0d_done_after_accept", id), int'(is7 ? done7 : done6), 0);
    endtask

    task automatic wait_done(input bit is7, input int id);
        for (int k = 0; k < 300 && !(is7 ? done7 : done6); k++) @(negedge clk);
        chk($sformatf("run%0d_done_within_budget", id), int'(is7 ? done7 : done6), 1);
        chk($sformatf("run%0d_busy_low_in_done", id), int'(is7 ? busy7 : busy6), 0);
    endtask

    initial begin
        logic [2303:0] mix;
        logic [2303:0] mix_exp;
        logic [2303:0] odd_in;
        logic [2303:0] odd_exp;

        reset  = 1'b0;
        start6 = 1'b0;
        start7 = 1'b0;
        in6    = '0;
        in7    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out6_nonzero", int'(out6 != '0), 0);
        chk("reset_busy6", int'(busy6), 0);
        chk("reset_done6", int'(done6), 0);
        chk("reset_out7_nonzero", int'(out7 != '0), 0);
        @(negedge clk);
        reset = 1'b1;

        // Ramp across all four channels
        in6 = ramp6();
        go(1'b0, 1, ramp6_exp(), 1'b1);
        wait_done(1'b0, 1);

        // All -5, with a data change and a start pulse landing at E10 of the run
        in6 = fill6(-5);
        go(1'b0, 2, '0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        in6    = ramp6();
        start6 = 1'b1;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        chk("run2_busy_after_start_in_run", int'(busy6), 1);
        wait_done(1'b0, 2);

        // Start from DONE picks up the changed data
        go(1'b0, 3, ramp6_exp(), 1'b1);
        wait_done(1'b0, 3);

        // Hand-built windows, everything else -5; channel 3 entirely -32768
        mix = fill6(-5);
        mix = put(mix, 0, -3);       mix = put(mix, 1, -1);
        mix = put(mix, 6, -7);       mix = put(mix, 7, -2);
        mix = put(mix, 2, -3);       mix = put(mix, 3, 4);
        mix = put(mix, 8, -7);       mix = put(mix, 9, 2);
        mix = put(mix, 36 + 0, 1);   mix = put(mix, 36 + 1, 2);
        mix = put(mix, 36 + 6, 9);   mix = put(mix, 36 + 7, 3);
        mix = put(mix, 36 + 14, 32767);  mix = put(mix, 36 + 15, -32768);
        mix = put(mix, 36 + 20, 0);      mix = put(mix, 36 + 21, 1);
        mix = put(mix, 72 + 28, 100);    mix = put(mix, 72 + 29, 50);
        mix = put(mix, 72 + 34, -1);     mix = put(mix, 72 + 35, 99);
        for (int i = 108; i < 144; i++) mix = put(mix, i, -32768);
        mix_exp = '0;
        mix_exp = put(mix_exp, 1, 4);
        mix_exp = put(mix_exp, 9, 9);
        mix_exp = put(mix_exp, 13, 32767);
        mix_exp = put(mix_exp, 26, 100);
        in6 = mix;
        go(1'b0, 4, OUT6_W'(mix_exp), 1'b1);
        wait_done(1'b0, 4);

        // Asynchronous reset at E50 of a ramp run
        in6 = ramp6();
        go(1'b0, 5, '0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrun_reset_out6_nonzero", int'(out6 != '0), 0);
        chk("midrun_reset_busy6", int'(busy6), 0);
        chk("midrun_reset_done6", int'(done6), 0);
        @(negedge clk);
        reset = 1'b1;
        go(1'b0, 6, ramp6_exp(), 1'b1);
        wait_done(1'b0, 6);

        // Odd side: last row and column hold large values that must never be read
        odd_in = '0;
        for (int i = 0; i < 49; i++)
            odd_in = put(odd_in, i, ((i / 7) == 6 || (i % 7) == 6) ? 30000 : i + 1);
        odd_exp = '0;
        for (int k = 0; k < 9; k++) odd_exp = put(odd_exp, k, odd_ramp[k]);
        in7 = IN7_W'(odd_in);
        go(1'b1, 7, OUT6_W'(odd_exp), 1'b1);
        wait_done(1'b1, 7);

        repeat (4) @(negedge clk);
        chk("pending_expect6", q6.size(), 0);
        chk("pending_expect7", q7.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
